// File: rtl/lookup_engine_tcam.sv
// Ternary match stage: 2-cycle pipelined lookup against a DEPTH-entry table written over the control AXIS.
// Optional feature macro LKE_HIT_CNT_EN adds saturating hit/miss counters.
module lookup_engine_tcam #(
    parameter int C_S_AXIS_DATA_WIDTH  = 512,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int STAGE_ID             = 0,
    parameter int PHV_LEN              = 1124,
    parameter int KEY_LEN              = 197,
    parameter int DEPTH                = 16,
    parameter int ACT_ADDR_W           = 8,
    parameter int LKE_ID               = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [PHV_LEN-1:0]                phv_in,
    input  logic [KEY_LEN-1:0]                key_in,
    input  logic [KEY_LEN-1:0]                key_mask_in,
    input  logic                              key_valid_in,
    output logic [PHV_LEN-1:0]                phv_out,
    output logic                              phv_valid_out,
    output logic                              hit_out,
    output logic [ACT_ADDR_W-1:0]             act_addr_out,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    c_s_axis_tdata,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_s_axis_tuser,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_s_axis_tkeep,
    input  logic                              c_s_axis_tvalid,
    input  logic                              c_s_axis_tlast,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
    output logic                              c_m_axis_tvalid,
    output logic                              c_m_axis_tlast
`ifdef LKE_HIT_CNT_EN
    ,
    output logic [31:0]                       hit_cnt,
    output logic [31:0]                       miss_cnt
`endif
);

    localparam int IDX_W         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int KEEP_W        = C_S_AXIS_DATA_WIDTH / 8;
    localparam int HDR_STAGE_LSB = 380;
    localparam int HDR_ID_LSB    = 376;
    localparam int HDR_IDX_LSB   = 368;
    localparam int CARE_LSB      = KEY_LEN;
    localparam int ACT_LSB       = 2 * KEY_LEN;
    localparam int ENT_VLD_BIT   = 511;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DRAIN,
        ST_FWD
    } ctrl_state_t;

    // ------------------------------------------------------------------
    // Table storage
    // ------------------------------------------------------------------
    logic [DEPTH-1:0]      ent_vld_q;
    logic [KEY_LEN-1:0]    ent_key_q  [DEPTH];
    logic [KEY_LEN-1:0]    ent_care_q [DEPTH];
    logic [ACT_ADDR_W-1:0] ent_act_q  [DEPTH];

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    ctrl_state_t state_q, state_d;
    logic [7:0]  idx_q;
    logic        hdr_match;
    logic        fwd_d;
    logic        beat1_acc;
    logic        wr_en;
    logic [IDX_W-1:0] wr_idx;

    assign hdr_match = (c_s_axis_tdata[HDR_STAGE_LSB +: 4] == 4'(STAGE_ID)) &&
                       (c_s_axis_tdata[HDR_ID_LSB +: 4] == 4'(LKE_ID));
    assign beat1_acc = (state_q == ST_HDR) && c_s_axis_tvalid;
    assign wr_en     = beat1_acc && ({24'd0, idx_q} < 32'(DEPTH));
    assign wr_idx    = idx_q[IDX_W-1:0];

    always_comb begin
        state_d = state_q;
        fwd_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (c_s_axis_tvalid) begin
                    if (hdr_match) begin
                        if (!c_s_axis_tlast) state_d = ST_HDR;
                    end else begin
                        fwd_d = 1'b1;
                        if (!c_s_axis_tlast) state_d = ST_FWD;
                    end
                end
            end
            ST_HDR: begin
                if (c_s_axis_tvalid) state_d = c_s_axis_tlast ? ST_IDLE : ST_DRAIN;
            end
            ST_DRAIN: begin
                if (c_s_axis_tvalid && c_s_axis_tlast) state_d = ST_IDLE;
            end
            ST_FWD: begin
                if (c_s_axis_tvalid) begin
                    fwd_d = 1'b1;
                    if (c_s_axis_tlast) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && c_s_axis_tvalid) idx_q <= c_s_axis_tdata[HDR_IDX_LSB +: 8];
        end
    end

    // Registered pass-through of non-matching control traffic
    logic [C_S_AXIS_DATA_WIDTH-1:0]  c_m_tdata_q;
    logic [C_S_AXIS_TUSER_WIDTH-1:0] c_m_tuser_q;
    logic [KEEP_W-1:0]               c_m_tkeep_q;
    logic                            c_m_tvalid_q;
    logic                            c_m_tlast_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            c_m_tdata_q  <= '0;
            c_m_tuser_q  <= '0;
            c_m_tkeep_q  <= '0;
            c_m_tvalid_q <= 1'b0;
            c_m_tlast_q  <= 1'b0;
        end else begin
            c_m_tvalid_q <= fwd_d;
            if (fwd_d) begin
                c_m_tdata_q <= c_s_axis_tdata;
                c_m_tuser_q <= c_s_axis_tuser;
                c_m_tkeep_q <= c_s_axis_tkeep;
                c_m_tlast_q <= c_s_axis_tlast;
            end
        end
    end

    assign c_m_axis_tdata  = c_m_tdata_q;
    assign c_m_axis_tuser  = c_m_tuser_q;
    assign c_m_axis_tkeep  = c_m_tkeep_q;
    assign c_m_axis_tvalid = c_m_tvalid_q;
    assign c_m_axis_tlast  = c_m_tlast_q;

    // ------------------------------------------------------------------
    // Table write. The shadow keeps the pre-write action of the rewritten
    // entry so a lookup already in flight still resolves to old contents.
    // ------------------------------------------------------------------
    logic                  shadow_vld_q;
    logic [IDX_W-1:0]      shadow_idx_q;
    logic [ACT_ADDR_W-1:0] shadow_act_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_vld_q    <= '0;
            shadow_vld_q <= 1'b0;
        end else begin
            shadow_vld_q <= wr_en;
            if (wr_en) ent_vld_q[wr_idx] <= c_s_axis_tdata[ENT_VLD_BIT];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ent_key_q[wr_idx]  <= c_s_axis_tdata[KEY_LEN-1:0];
            ent_care_q[wr_idx] <= c_s_axis_tdata[CARE_LSB +: KEY_LEN];
            ent_act_q[wr_idx]  <= c_s_axis_tdata[ACT_LSB +: ACT_ADDR_W];
            shadow_idx_q       <= wr_idx;
            shadow_act_q       <= ent_act_q[wr_idx];
        end
    end

    // ------------------------------------------------------------------
    // Lookup stage 1: parallel ternary compare
    // ------------------------------------------------------------------
    logic [DEPTH-1:0]   hit_vec_d;
    logic [DEPTH-1:0]   hit_vec_q;
    logic [PHV_LEN-1:0] phv1_q;
    logic               vld1_q;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign hit_vec_d[gi] = ent_vld_q[gi] &
                                   ~|((key_in ^ ent_key_q[gi]) & ent_care_q[gi] & key_mask_in);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            vld1_q    <= 1'b0;
            hit_vec_q <= '0;
            phv1_q    <= '0;
        end else begin
            vld1_q <= key_valid_in;
            if (key_valid_in) begin
                hit_vec_q <= hit_vec_d;
                phv1_q    <= phv_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Lookup stage 2: lowest-index priority encode
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]      win_idx;
    logic                  any_hit;
    logic [ACT_ADDR_W-1:0] act_sel;

    always_comb begin
        win_idx = '0;
        any_hit = |hit_vec_q;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (hit_vec_q[i]) win_idx = IDX_W'(i);
        end
    end

    assign act_sel = (shadow_vld_q && shadow_idx_q == win_idx) ? shadow_act_q : ent_act_q[win_idx];

    logic [PHV_LEN-1:0]    phv_out_q;
    logic                  phv_valid_out_q;
    logic                  hit_out_q;
    logic [ACT_ADDR_W-1:0] act_addr_out_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            phv_out_q       <= '0;
            phv_valid_out_q <= 1'b0;
            hit_out_q       <= 1'b0;
            act_addr_out_q  <= '0;
        end else begin
            phv_valid_out_q <= vld1_q;
            if (vld1_q) begin
                phv_out_q      <= phv1_q;
                hit_out_q      <= any_hit;
                act_addr_out_q <= any_hit ? act_sel : '0;
            end
        end
    end

    assign phv_out       = phv_out_q;
    assign phv_valid_out = phv_valid_out_q;
    assign hit_out       = hit_out_q;
    assign act_addr_out  = act_addr_out_q;

`ifdef LKE_HIT_CNT_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;
    logic        cnt_clr;

    // Index 8'hFF in a matching packet is a counter-clear command
    assign cnt_clr = beat1_acc && (idx_q == 8'hFF);

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (phv_valid_out_q) begin
            if (hit_out_q) begin
                if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
                if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_lookup_engine_tcam.sv
// Scoreboard bench for lookup_engine_tcam: directed table scenarios followed by random lookups and control traffic.
module tb_lookup_engine_tcam;

    localparam int DW       = 512;
    localparam int UW       = 128;
    localparam int KW       = DW / 8;
    localparam int STAGE_ID = 0;
    localparam int PHV_LEN  = 1124;
    localparam int KEY_LEN  = 197;
    localparam int DEPTH    = 16;
    localparam int AW       = 8;
    localparam int LKE_ID   = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [PHV_LEN-1:0] phv_in = '0;
    logic [KEY_LEN-1:0] key_in = '0;
    logic [KEY_LEN-1:0] key_mask_in = '0;
    logic               key_valid_in = 1'b0;
    logic [PHV_LEN-1:0] phv_out;
    logic               phv_valid_out;
    logic               hit_out;
    logic [AW-1:0]      act_addr_out;
    logic [DW-1:0]      c_s_axis_tdata = '0;
    logic [UW-1:0]      c_s_axis_tuser = '0;
    logic [KW-1:0]      c_s_axis_tkeep = '0;
    logic               c_s_axis_tvalid = 1'b0;
    logic               c_s_axis_tlast = 1'b0;
    logic [DW-1:0]      c_m_axis_tdata;
    logic [UW-1:0]      c_m_axis_tuser;
    logic [KW-1:0]      c_m_axis_tkeep;
    logic               c_m_axis_tvalid;
    logic               c_m_axis_tlast;
`ifdef LKE_HIT_CNT_EN
    logic [31:0]        hit_cnt;
    logic [31:0]        miss_cnt;
`endif

    lookup_engine_tcam dut (
        .clk             (clk),
        .rst             (rst),
        .phv_in          (phv_in),
        .key_in          (key_in),
        .key_mask_in     (key_mask_in),
        .key_valid_in    (key_valid_in),
        .phv_out         (phv_out),
        .phv_valid_out   (phv_valid_out),
        .hit_out         (hit_out),
        .act_addr_out    (act_addr_out),
        .c_s_axis_tdata  (c_s_axis_tdata),
        .c_s_axis_tuser  (c_s_axis_tuser),
        .c_s_axis_tkeep  (c_s_axis_tkeep),
        .c_s_axis_tvalid (c_s_axis_tvalid),
        .c_s_axis_tlast  (c_s_axis_tlast),
        .c_m_axis_tdata  (c_m_axis_tdata),
        .c_m_axis_tuser  (c_m_axis_tuser),
        .c_m_axis_tkeep  (c_m_axis_tkeep),
        .c_m_axis_tvalid (c_m_axis_tvalid),
        .c_m_axis_tlast  (c_m_axis_tlast)
`ifdef LKE_HIT_CNT_EN
        ,
        .hit_cnt         (hit_cnt),
        .miss_cnt        (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PHV_LEN-1:0] phv;
        logic               hit;
        logic [AW-1:0]      act;
    } lk_exp_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    // One control beat plus what the table/forward path should do with it
    typedef struct {
        beat_t              b;
        bit                 fwd;
        bit                 wr;
        int                 idx;
        logic [KEY_LEN-1:0] key;
        logic [KEY_LEN-1:0] care;
        logic [AW-1:0]      act;
        bit                 vld;
    } ctl_t;

    lk_exp_t lk_q[$];
    beat_t   fwd_q[$];
    ctl_t    ctl_pend[$];

    bit                 m_vld  [DEPTH];
    logic [KEY_LEN-1:0] m_key  [DEPTH];
    logic [KEY_LEN-1:0] m_care [DEPTH];
    logic [AW-1:0]      m_act  [DEPTH];

    int n_checks = 0;
    int n_pass   = 0;
    int n_lookups = 0;

    logic [KEY_LEN-1:0] all1 = '1;
    logic [KEY_LEN-1:0] base_key;
    logic [KEY_LEN-1:0] k2 = 197'hcccc_bbbb;

    task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic chk_phv(input logic [PHV_LEN-1:0] got, input logic [PHV_LEN-1:0] exp);
        logic [127:0] g_lo;
        logic [127:0] e_lo;
        g_lo = got[127:0];
        e_lo = exp[127:0];
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL phv_out: got[127:0] %h expected[127:0] %h (full vectors differ)", g_lo, e_lo);
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        for (int j = 0; j < DW / 32; j++) d[j*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [PHV_LEN-1:0] rnd_phv();
        logic [PHV_LEN-1:0] p;
        p = '0;
        for (int j = 0; j < (PHV_LEN + 31) / 32; j++) p = {p[PHV_LEN-33:0], 32'($urandom)};
        return p;
    endfunction

    // Reference: first valid entry whose cared-and-masked bits all agree
    function automatic lk_exp_t ref_lookup(input logic [KEY_LEN-1:0] k, input logic [KEY_LEN-1:0] m,
                                           input logic [PHV_LEN-1:0] p);
        lk_exp_t e;
        e.phv = p;
        e.hit = 1'b0;
        e.act = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_vld[i] && (((k ^ m_key[i]) & m_care[i] & m) == '0)) begin
                e.hit = 1'b1;
                e.act = m_act[i];
                break;
            end
        end
        return e;
    endfunction

    function automatic ctl_t mk(input logic [DW-1:0] d, input bit last);
        ctl_t c;
        c.b.data = d;
        c.b.user = {4{$urandom}};
        c.b.keep = {2{$urandom}};
        c.b.last = last;
        c.fwd = 1'b0;
        c.wr  = 1'b0;
        c.idx = 0;
        c.key = '0;
        c.care = '0;
        c.act = '0;
        c.vld = 1'b0;
        return c;
    endfunction

    task automatic pkt_write(input int idx, input logic [KEY_LEN-1:0] k, input logic [KEY_LEN-1:0] cr,
                             input logic [AW-1:0] a, input bit v, input int extra);
        ctl_t c;
        logic [DW-1:0] d;
        d = rnd_data();
        d[383:376] = {4'(STAGE_ID), 4'(LKE_ID)};
        d[375:368] = 8'(idx);
        ctl_pend.push_back(mk(d, 1'b0));
        d = rnd_data();
        d[KEY_LEN-1:0] = k;
        d[2*KEY_LEN-1:KEY_LEN] = cr;
        d[2*KEY_LEN+AW-1:2*KEY_LEN] = a;
        d[511] = v;
        c = mk(d, extra == 0);
        c.wr = (idx < DEPTH);
        c.idx = idx;
        c.key = k;
        c.care = cr;
        c.act = a;
        c.vld = v;
        ctl_pend.push_back(c);
        for (int j = 0; j < extra; j++) ctl_pend.push_back(mk(rnd_data(), j == extra - 1));
    endtask

    task automatic pkt_hdr_only(input int idx);
        logic [DW-1:0] d;
        d = rnd_data();
        d[383:376] = {4'(STAGE_ID), 4'(LKE_ID)};
        d[375:368] = 8'(idx);
        ctl_pend.push_back(mk(d, 1'b1));
    endtask

    task automatic pkt_foreign(input int nbeats, input bit stage_ok);
        ctl_t c;
        logic [DW-1:0] d;
        for (int j = 0; j < nbeats; j++) begin
            d = rnd_data();
            if (j == 0) begin
                if (stage_ok) d[383:376] = {4'(STAGE_ID), 4'(LKE_ID + 1 + $urandom_range(0, 12))};
                else          d[383:380] = 4'(STAGE_ID + 1 + $urandom_range(0, 14));
            end
            c = mk(d, j == nbeats - 1);
            c.fwd = 1'b1;
            ctl_pend.push_back(c);
        end
    endtask

    // One clock: drive inputs, record expectations against the pre-edge table, then apply any write
    task automatic step(input bit lk, input logic [KEY_LEN-1:0] k, input logic [KEY_LEN-1:0] m, input bit ctl);
        ctl_t c;
        logic [PHV_LEN-1:0] p;
        p = rnd_phv();
        key_valid_in = lk;
        key_in = k;
        key_mask_in = m;
        phv_in = p;
        if (lk) lk_q.push_back(ref_lookup(k, m, p));
        if (ctl && ctl_pend.size() > 0) begin
            c = ctl_pend.pop_front();
            c_s_axis_tvalid = 1'b1;
            c_s_axis_tdata  = c.b.data;
            c_s_axis_tuser  = c.b.user;
            c_s_axis_tkeep  = c.b.keep;
            c_s_axis_tlast  = c.b.last;
            if (c.fwd) fwd_q.push_back(c.b);
            if (c.wr) begin
                m_vld[c.idx]  = c.vld;
                m_key[c.idx]  = c.key;
                m_care[c.idx] = c.care;
                m_act[c.idx]  = c.act;
            end
        end else begin
            c_s_axis_tvalid = 1'b0;
            c_s_axis_tdata  = rnd_data();
            c_s_axis_tlast  = $urandom_range(0, 1) == 1;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, '0, 1'b0);
    endtask

    task automatic run_ctl();
        while (ctl_pend.size() > 0) step(1'b0, '0, '0, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        key_valid_in = 1'b0;
        c_s_axis_tvalid = 1'b0;
        ctl_pend.delete();
        for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_phv_valid_out", DW'(phv_valid_out), '0);
        chk("rst_hit_out", DW'(hit_out), '0);
        chk("rst_act_addr_out", DW'(act_addr_out), '0);
        chk("rst_c_m_axis_tvalid", DW'(c_m_axis_tvalid), '0);
        chk("rst_phv_out_low", DW'(phv_out[DW-1:0]), '0);
        rst = 1'b0;
    endtask

    // Monitor: pop the scoreboard whenever the DUT presents a result or a forwarded beat
    always @(negedge clk) begin
        lk_exp_t e;
        beat_t   b;
        if (phv_valid_out === 1'b1) begin
            if (lk_q.size() == 0) begin
                n_checks++;
                $display("FAIL lookup_extra: got phv_valid_out=1 expected no pending lookup");
            end else begin
                e = lk_q.pop_front();
                n_lookups++;
                $display("lookup %0d: hit=%0d act=%0h (expected hit=%0d act=%0h)",
                         n_lookups, hit_out, act_addr_out, e.hit, e.act);
                chk_phv(phv_out, e.phv);
                chk("hit_out", DW'(hit_out), DW'(e.hit));
                chk("act_addr_out", DW'(act_addr_out), DW'(e.act));
            end
        end
        if (c_m_axis_tvalid === 1'b1) begin
            if (fwd_q.size() == 0) begin
                n_checks++;
                $display("FAIL fwd_extra: got c_m_axis_tvalid=1 expected no pending forward");
            end else begin
                b = fwd_q.pop_front();
                $display("forward beat: last=%0d", c_m_axis_tlast);
                chk("c_m_axis_tdata", c_m_axis_tdata, b.data);
                chk("c_m_axis_tuser", DW'(c_m_axis_tuser), DW'(b.user));
                chk("c_m_axis_tkeep", DW'(c_m_axis_tkeep), DW'(b.keep));
                chk("c_m_axis_tlast", DW'(c_m_axis_tlast), DW'(b.last));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        base_key = '0;
        for (int j = 0; j < 7; j++) base_key = {base_key[KEY_LEN-33:0], 32'($urandom)};
        for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;

        do_reset();

        // T1: empty table misses
        step(1'b1, 197'h1, all1, 1'b0);
        idle(3);

        // T2: exact entry at idx3
        pkt_write(3, k2, all1, 8'h21, 1'b1, 0);
        run_ctl();
        step(1'b1, k2, all1, 1'b0);
        idle(3);

        // T3: wildcard at idx1 wins over idx3
        pkt_write(1, base_key, '0, 8'h05, 1'b1, 1);
        run_ctl();
        step(1'b1, base_key ^ 197'h5a5a, $urandom, 1'b0);
        step(1'b1, k2, all1, 1'b0);
        idle(3);

        // T4: remove wildcard, then hit/miss/hit back to back
        pkt_write(1, '0, '0, 8'h00, 1'b0, 0);
        run_ctl();
        step(1'b1, k2, all1, 1'b0);
        step(1'b1, k2 ^ 197'h1, all1, 1'b0);
        step(1'b1, k2, all1, 1'b0);
        idle(3);

        // T5: foreign packets forwarded, header-only packet consumed, table intact
        pkt_foreign(2, 1'b0);
        run_ctl();
        pkt_foreign(3, 1'b1);
        pkt_hdr_only(5);
        pkt_foreign(1, 1'b0);
        run_ctl();
        step(1'b1, k2, all1, 1'b0);
        idle(3);

        // T6: lookup on the write edge sees old action, next lookup sees new
        pkt_write(3, k2, all1, 8'h33, 1'b1, 0);
        step(1'b0, '0, '0, 1'b1);
        step(1'b1, k2, all1, 1'b1);
        step(1'b1, k2, all1, 1'b0);
        idle(3);

        // Out-of-range indices must not write
        pkt_write(DEPTH, k2, all1, 8'h77, 1'b1, 0);
        pkt_write(255, k2, all1, 8'h78, 1'b1, 1);
        run_ctl();
        step(1'b1, k2, all1, 1'b0);
        idle(3);

        // Reset between header and data beat
        pkt_write(0, k2, all1, 8'h44, 1'b1, 0);
        step(1'b0, '0, '0, 1'b1);
        do_reset();
        step(1'b1, k2, all1, 1'b0);
        idle(3);
        pkt_foreign(2, 1'b0);
        run_ctl();
        idle(3);

        // Random traffic
        for (int cyc = 0; cyc < 1500; cyc++) begin
            logic [KEY_LEN-1:0] rk;
            logic [KEY_LEN-1:0] rc;
            logic [KEY_LEN-1:0] rm;
            int kind;
            if (ctl_pend.size() < 3) begin
                kind = $urandom_range(0, 7);
                rc = ($urandom_range(0, 15) == 0) ? '0 : ~KEY_LEN'($urandom_range(0, 63));
                rk = base_key ^ KEY_LEN'($urandom_range(0, 63));
                if (kind <= 4)
                    pkt_write($urandom_range(0, DEPTH - 1), rk, rc, 8'($urandom), $urandom_range(0, 4) != 0,
                              $urandom_range(0, 2));
                else if (kind == 5)
                    pkt_write(($urandom_range(0, 1) == 1) ? 255 : $urandom_range(DEPTH, DEPTH + 8),
                              rk, rc, 8'($urandom), 1'b1, $urandom_range(0, 1));
                else if (kind == 6)
                    pkt_hdr_only($urandom_range(0, DEPTH - 1));
                else
                    pkt_foreign($urandom_range(1, 3), $urandom_range(0, 1) == 1);
            end
            rk = base_key ^ KEY_LEN'($urandom_range(0, 63));
            if ($urandom_range(0, 9) == 0) rk = rk ^ {KEY_LEN{1'b1}};
            rm = ~KEY_LEN'($urandom_range(0, 63));
            step($urandom_range(0, 3) != 0, rk, rm, $urandom_range(0, 2) != 0);
        end
        run_ctl();
        idle(6);

        chk("lookup_queue_drained", DW'(lk_q.size()), '0);
        chk("forward_queue_drained", DW'(fwd_q.size()), '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
